// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Only the read register is reset; the storage array keeps its contents.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with registered count, decoded level flags and optional
// sticky overflow/underflow flags (enabled by defining SYNC_FIFO_ERR_EN).
module sync_fifo_v2
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int  DEPTH      = FIFO_DEPTH,
  parameter int  AF_THRESH  = DEPTH - 2,
  parameter int  AE_THRESH  = 2,
  localparam int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                wr_acc, rd_acc;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (din),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (dout)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error in the same cycle as err_clr takes priority over the clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Scoreboard bench for sync_fifo_v2: directed scenarios then randomized
// traffic, compared against a queue-based reference model.
module tb_sync_fifo_v2;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty;
  logic [4:0]    count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            is_read;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] last_dout = '0;
  bit            ovf_m = 1'b0;
  bit            udf_m = 1'b0;

  sync_fifo_v2 #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int n;
    n = model_q.size();
    check("count", 32'(count), n);
    check("full", 32'(full), 32'(n == DEPTH));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("underflow", 32'(underflow), 32'(udf_m));
  endtask

  // One clock of stimulus; the model applies the acceptance rules to the
  // pre-edge fill level and queues the dout value due after the edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit wr_ok, rd_ok;
    int n;
    wr_en = w; din = d; rd_en = r; err_clr = c;
    @(posedge clk);
    n = model_q.size();
    wr_ok = w && (n < DEPTH);
    rd_ok = r && (n > 0);
`ifdef SYNC_FIFO_ERR_EN
    if (c) begin
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end
    if (w && n == DEPTH) ovf_m = 1'b1;
    if (r && n == 0)     udf_m = 1'b1;
`endif
    if (rd_ok) last_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
    exp_q.push_back('{data: last_dout, is_read: rd_ok});
    #1;
    check_status();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    last_dout = '0;
    ovf_m = 1'b0;
    udf_m = 1'b0;
  endtask

  // Pulse rst_n low between clock edges and check outputs before any edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status();
    check("reset_dout", 32'(dout), 32'h0);
    #10;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.is_read ? "read_data" : "dout_hold", 32'(dout), 32'(e.data));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : driver
    logic [DW-1:0] rnd;
    // Power-on reset
    #1;
    check_status();
    check("reset_dout", 32'(dout), 32'h0);
    #22;
    rst_n = 1'b1;

    // Fill 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    // Drain, then idle to confirm dout holds the last word
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Empty with simultaneous read and write
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Streaming at count=8 so pointers wrap repeatedly
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation at count=5
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    async_reset();
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic: write-heavy, read-heavy, then balanced
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 300; i++) begin
        int wp, rp;
        wp = (phase == 0) ? 80 : (phase == 1) ? 25 : 50;
        rp = (phase == 0) ? 25 : (phase == 1) ? 80 : 50;
        rnd = DW'($urandom);
        cycle($urandom_range(0, 99) < wp, rnd, $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 5);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
